// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Purpose  : Programmable SPI serial-clock generator. Emits a runtime
//            selectable number of SCLK pulses at a runtime selectable
//            half-period, in any CPOL/CPHA mode, together with one-cycle
//            leading/trailing edge strobes mapped onto sample/shift strobes
//            for the shift register, and busy/done handshaking. Supports a
//            clean abort.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-low reset
//            start      - request a transaction (accepted in IDLE only)
//            abort      - terminate the current transaction
//            clk_div    - SCLK half-period in clk cycles (0 treated as 1)
//            n_pulses   - SCLK pulse count (clamped to SPI_MAXLEN)
//            cpol/cpha  - SPI mode
//            spi_clk    - registered serial clock
//            lead_edge  - strobe, idle->active SCLK edge
//            trail_edge - strobe, active->idle SCLK edge
//            sample_stb - sampling strobe (lead if cpha=0, else trail)
//            shift_stb  - shifting strobe (trail if cpha=0, else lead)
//            busy       - transaction in progress
//            done       - one-cycle pulse on normal completion
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
  parameter int SPI_MAXLEN = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic [$clog2(SPI_MAXLEN):0]   n_pulses,
  input  logic                          cpol,
  input  logic                          cpha,
  output logic                          spi_clk,
  output logic                          lead_edge,
  output logic                          trail_edge,
  output logic                          sample_stb,
  output logic                          shift_stb,
  output logic                          busy,
  output logic                          done
);

  localparam int c_NP_W = $clog2(SPI_MAXLEN) + 1;
  localparam int c_EC_W = $clog2(2 * SPI_MAXLEN) + 1;

  localparam logic [c_NP_W-1:0]    c_MAXLEN_NP = c_NP_W'(SPI_MAXLEN);
  localparam logic [DIV_WIDTH-1:0] c_DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [c_EC_W-1:0]    c_EC_ONE    = c_EC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [c_EC_W-1:0]      edges_q, edges_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   spi_clk_q, spi_clk_d;
  logic                   lead_q, lead_d;
  logic                   trail_q, trail_d;
  logic                   done_q, done_d;

  logic [DIV_WIDTH-1:0]   w_div_eff;
  logic [c_NP_W-1:0]      w_n_eff;

  assign w_div_eff = (clk_div == '0) ? c_DIV_ONE : clk_div;
  assign w_n_eff   = (n_pulses > c_MAXLEN_NP) ? c_MAXLEN_NP : n_pulses;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      edges_q   <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      spi_clk_q <= 1'b0;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edges_q   <= edges_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      spi_clk_q <= spi_clk_d;
      lead_q    <= lead_d;
      trail_q   <= trail_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edges_d   = edges_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    spi_clk_d = spi_clk_q;
    lead_d    = 1'b0;
    trail_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        spi_clk_d = cpol;
        // done_q marks the completion cycle; a start seen then is dropped.
        if (start && !done_q) begin
          if (w_n_eff == '0) begin
            done_d = 1'b1;
          end else begin
            cpol_d  = cpol;
            cpha_d  = cpha;
            div_d   = w_div_eff;
            edges_d = c_EC_W'({w_n_eff, 1'b0});
            cnt_d   = w_div_eff - c_DIV_ONE;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d   = ST_IDLE;
          spi_clk_d = cpol_q;
          cnt_d     = '0;
          edges_d   = '0;
        end else if (cnt_q == '0) begin
          spi_clk_d = ~spi_clk_q;
          cnt_d     = div_q - c_DIV_ONE;
          edges_d   = edges_q - c_EC_ONE;
          // An even remaining count means the clock is at its idle level,
          // so this edge leaves idle (leading); odd means it returns.
          if (!edges_q[0]) begin
            lead_d = 1'b1;
          end else begin
            trail_d = 1'b1;
          end
          if (edges_q == c_EC_ONE) begin
            state_d = ST_TAIL;
          end
        end else begin
          cnt_d = cnt_q - c_DIV_ONE;
        end
      end

      ST_TAIL: begin
        if (abort) begin
          state_d   = ST_IDLE;
          spi_clk_d = cpol_q;
          cnt_d     = '0;
          edges_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - c_DIV_ONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        spi_clk_d = cpol;
      end
    endcase
  end

  assign spi_clk    = spi_clk_q;
  assign lead_edge  = lead_q;
  assign trail_edge = trail_q;
  assign sample_stb = cpha_q ? trail_q : lead_q;
  assign shift_stb  = cpha_q ? lead_q : trail_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
`default_nettype wire
